dc_update_scheduler: RTL and testbench

Sits between the DC frame dispatcher and the shared DAC serial writer. Takes decoded DC frames (per-channel payload plus channel select) and streams each payload word-by-word to the single DAC writer, then pulses the DAC load strobe. It double-buffers one pending frame so the dispatcher is never stalled. Launch commands are held back until all DC updates have settled, so a launch always sees final DAC levels.

---
 rtl/dc_update_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_dc_update_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_update_scheduler.sv
// dc_update_scheduler
//   Streams decoded DC frames word by word to the shared DAC serial writer,
//   then settles and pulses the DAC load strobe. One pending frame is held in
//   a shadow buffer so the dispatcher never stalls; the newest frame wins if a
//   second one arrives while the shadow is occupied. Launch commands are held
//   until no DC update is in flight or queued.
//
//   Ports:
//     i_clk, i_rst_n          clock, asynchronous active-low reset
//     i_dc_regs               FRAME_WORDS x 32-bit frame (word 0 = header)
//     i_channel_sel           DAC channel of the frame
//     i_valid_frame           one-cycle frame strobe
//     i_launch_cmd/_valid     launch command and its one-cycle strobe
//     o_word_data/_chan       payload word and its channel tag
//     o_word_valid/_last      word valid, last-word marker
//     i_word_ready            DAC writer ready
//     o_ldac                  DAC load strobe (LDAC_WIDTH cycles)
//     o_busy                  streaming, frame queued, or launch pending
//     o_launch_cmd/_go        released launch command and one-cycle pulse
//     o_drop_cnt              saturating count of overwritten shadow frames
//
//   Build option: define DC_SCHED_DROP_CNT_EN to build the drop counter;
//   otherwise o_drop_cnt is tied to zero.

module dc_update_scheduler #(
    parameter int FRAME_WORDS   = 62,
    parameter int SETTLE_CYCLES = 16,
    parameter int LDAC_WIDTH    = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [FRAME_WORDS*32-1:0] i_dc_regs,
    input  logic [4:0]                i_channel_sel,
    input  logic                      i_valid_frame,
    input  logic [127:0]              i_launch_cmd,
    input  logic                      i_launch_valid,
    output logic [31:0]               o_word_data,
    output logic [4:0]                o_word_chan,
    output logic                      o_word_valid,
    output logic                      o_word_last,
    input  logic                      i_word_ready,
    output logic                      o_ldac,
    output logic                      o_busy,
    output logic [127:0]              o_launch_cmd,
    output logic                      o_launch_go,
    output logic [7:0]                o_drop_cnt
);

    localparam int IDX_W = $clog2(FRAME_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_LDAC   = 2'd3;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [15:0]      settle_cnt, settle_nxt;
    logic [15:0]      ldac_cnt, ldac_nxt;

    logic [31:0]      active_words [FRAME_WORDS];
    logic [31:0]      shadow_words [FRAME_WORDS];
    logic [4:0]       active_chan, shadow_chan;
    logic             shadow_full, shadow_full_nxt;
    logic [127:0]     pend_cmd;
    logic             launch_pending, launch_pending_nxt;

    logic             take_shadow, take_input, to_shadow, handshake, fire_launch;

    always_comb begin
        // In IDLE a queued shadow frame always goes ahead of a new arrival.
        take_shadow = (state == ST_IDLE) && shadow_full;
        take_input  = (state == ST_IDLE) && !shadow_full && i_valid_frame;
        to_shadow   = i_valid_frame && !take_input;
        handshake   = (state == ST_STREAM) && i_word_ready;
        fire_launch = (state == ST_IDLE) && !shadow_full && !i_valid_frame && launch_pending;

        shadow_full_nxt    = to_shadow ? 1'b1 : (take_shadow ? 1'b0 : shadow_full);
        launch_pending_nxt = i_launch_valid ? 1'b1 : (fire_launch ? 1'b0 : launch_pending);

        state_nxt  = state;
        idx_nxt    = idx;
        settle_nxt = settle_cnt;
        ldac_nxt   = ldac_cnt;
        case (state)
            ST_IDLE: begin
                if (take_shadow || take_input) begin
                    state_nxt = ST_STREAM;
                    idx_nxt   = IDX_W'(1);
                end
            end
            ST_STREAM: begin
                if (handshake) begin
                    if (idx == LAST_IDX) begin
                        if (SETTLE_CYCLES > 0) begin
                            state_nxt  = ST_SETTLE;
                            settle_nxt = '0;
                        end else begin
                            state_nxt = ST_LDAC;
                            ldac_nxt  = '0;
                        end
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == 16'(SETTLE_CYCLES - 1)) begin
                    state_nxt = ST_LDAC;
                    ldac_nxt  = '0;
                end else begin
                    settle_nxt = settle_cnt + 16'd1;
                end
            end
            ST_LDAC: begin
                if (ldac_cnt == 16'(LDAC_WIDTH - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    ldac_nxt = ldac_cnt + 16'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs are loaded from next-state values so they line up
    // with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            ldac_cnt       <= '0;
            shadow_full    <= 1'b0;
            launch_pending <= 1'b0;
            pend_cmd       <= '0;
            o_word_valid   <= 1'b0;
            o_ldac         <= 1'b0;
            o_busy         <= 1'b0;
            o_launch_go    <= 1'b0;
            o_launch_cmd   <= '0;
        end else begin
            state          <= state_nxt;
            idx            <= idx_nxt;
            settle_cnt     <= settle_nxt;
            ldac_cnt       <= ldac_nxt;
            shadow_full    <= shadow_full_nxt;
            launch_pending <= launch_pending_nxt;
            o_word_valid   <= (state_nxt == ST_STREAM);
            o_ldac         <= (state_nxt == ST_LDAC);
            o_busy         <= (state_nxt != ST_IDLE) || shadow_full_nxt || launch_pending_nxt;
            o_launch_go    <= fire_launch;
            // The released command is the one pending before any same-cycle
            // arrival; a new arrival stays pending for a later release.
            if (fire_launch)
                o_launch_cmd <= pend_cmd;
            if (i_launch_valid)
                pend_cmd <= i_launch_cmd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned k = 0; k < FRAME_WORDS; k++) begin
                active_words[k] <= '0;
                shadow_words[k] <= '0;
            end
            active_chan <= '0;
            shadow_chan <= '0;
        end else begin
            if (take_shadow) begin
                active_words <= shadow_words;
                active_chan  <= shadow_chan;
            end else if (take_input) begin
                for (int unsigned k = 0; k < FRAME_WORDS; k++)
                    active_words[k] <= i_dc_regs[32*k +: 32];
                active_chan <= i_channel_sel;
            end
            if (to_shadow) begin
                for (int unsigned k = 0; k < FRAME_WORDS; k++)
                    shadow_words[k] <= i_dc_regs[32*k +: 32];
                shadow_chan <= i_channel_sel;
            end
        end
    end

    assign o_word_data = active_words[idx];
    assign o_word_chan = active_chan;
    assign o_word_last = o_word_valid && (idx == LAST_IDX);

`ifdef DC_SCHED_DROP_CNT_EN
    // A drop is an arrival that lands on an occupied shadow which is not
    // being moved to active in the same cycle.
    logic       drop_ev;
    logic [7:0] drop_cnt;

    assign drop_ev = i_valid_frame && shadow_full && (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            drop_cnt <= '0;
        else if (drop_ev && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end

    assign o_drop_cnt = drop_cnt;
`else
    assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dc_update_scheduler.sv
// Self-checking bench for dc_update_scheduler: a vector table of single
// frames under different ready patterns, then hand-written sequences for
// shadow overwrite, launch hold-off and mid-stream reset. Streamed words are
// checked against a scoreboard queue filled when each frame is driven.

module tb_dc_update_scheduler;

    localparam int FW = 62;
    localparam int SC = 16;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [FW*32-1:0] dc_regs;
    logic [4:0]      channel_sel;
    logic            valid_frame;
    logic [127:0]    launch_cmd;
    logic            launch_valid;
    logic [31:0]     word_data;
    logic [4:0]      word_chan;
    logic            word_valid;
    logic            word_last;
    logic            word_ready;
    logic            ldac;
    logic            busy;
    logic [127:0]    launch_cmd_out;
    logic            launch_go;
    logic [7:0]      drop_cnt;

    dc_update_scheduler #(
        .FRAME_WORDS  (FW),
        .SETTLE_CYCLES(SC),
        .LDAC_WIDTH   (LW)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_dc_regs     (dc_regs),
        .i_channel_sel (channel_sel),
        .i_valid_frame (valid_frame),
        .i_launch_cmd  (launch_cmd),
        .i_launch_valid(launch_valid),
        .o_word_data   (word_data),
        .o_word_chan   (word_chan),
        .o_word_valid  (word_valid),
        .o_word_last   (word_last),
        .i_word_ready  (word_ready),
        .o_ldac        (ldac),
        .o_busy        (busy),
        .o_launch_cmd  (launch_cmd_out),
        .o_launch_go   (launch_go),
        .o_drop_cnt    (drop_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  chan;
        logic        last;
    } exp_word_t;

    typedef struct {
        logic [4:0]  chan;
        logic [31:0] base;
        int          ready_mode;
        int          exp_hs;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    exp_word_t   sb[$];
    exp_word_t   mon_e;
    vec_t        vecs[4];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          hs_cnt = 0;
    int          ldac_rise_cnt = 0;
    int          go_cnt = 0;
    int          last_hs_cyc = 0;
    int          ldac_start = 0;
    bit          last_hs_valid = 0;
    bit          ldac_done = 0;
    logic [31:0] last_data = '0;
    logic [127:0] exp_cmd = '0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = '0;
    logic [4:0]  prev_chan = '0;
    logic        prev_ldac = 1'b0;
    logic        prev_go = 1'b0;
    logic [7:0]  exp_drop;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        word_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       word_ready = 1'b1;
                1:       word_ready = ~word_ready;
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 0;
            prev_ldac  = 1'b0;
            prev_go    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", word_valid, 1);
                chk("stall_data", word_data, prev_data);
                chk("stall_chan", word_chan, prev_chan);
            end
            if (word_valid && word_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: actual=word %0h required=no word", word_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("word_data", word_data, mon_e.data);
                    chk("word_chan", word_chan, mon_e.chan);
                    chk("word_last", word_last, mon_e.last);
                end
                if (word_last) begin
                    last_hs_cyc   = cyc;
                    last_hs_valid = 1;
                    last_data     = word_data;
                end
            end
            prev_stall = word_valid && !word_ready;
            prev_data  = word_data;
            prev_chan  = word_chan;
            if (ldac && !prev_ldac) begin
                ldac_rise_cnt++;
                ldac_start = cyc;
                if (last_hs_valid) begin
                    chk("ldac_delay", cyc - last_hs_cyc, SC + 1);
                    last_hs_valid = 0;
                end
            end
            if (!ldac && prev_ldac) begin
                chk("ldac_width", cyc - ldac_start, LW);
                ldac_done = 1;
            end
            if (launch_go) begin
                go_cnt++;
                chk("go_cmd", launch_cmd_out, exp_cmd);
                chk("go_no_ldac", ldac, 0);
                chk("go_after_ldac", ldac_done, 1);
                chk("go_single", prev_go, 0);
            end
            prev_ldac = ldac;
            prev_go   = launch_go;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit fv, input bit push, input logic [4:0] ch,
                         input logic [31:0] base, input bit lv, input logic [127:0] cmd);
        @(posedge clk);
        #1;
        valid_frame  = fv;
        channel_sel  = ch;
        for (int k = 0; k < FW; k++)
            dc_regs[32*k +: 32] = base + 32'(k);
        launch_valid = lv;
        launch_cmd   = cmd;
        if (fv && push)
            for (int k = 1; k < FW; k++)
                sb.push_back('{data: base + 32'(k), chan: ch, last: (k == FW - 1)});
        if (fv)
            ldac_done = 0;
        if (lv)
            exp_cmd = cmd;
        @(posedge clk);
        #1;
        valid_frame  = 1'b0;
        launch_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
            if (busy === 1'b0)
                done = 1;
        end
        chk({"idle_", nm}, done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int r_ldac, r_go, r_hs;

        rst_n        = 1'b0;
        dc_regs      = '0;
        channel_sel  = '0;
        valid_frame  = 1'b0;
        launch_cmd   = '0;
        launch_valid = 1'b0;
`ifdef DC_SCHED_DROP_CNT_EN
        exp_drop = 8'd1;
`else
        exp_drop = 8'd0;
`endif

        vecs[0] = '{5'd7,  32'hA000_0000, 0, 61, 32'hA000_0001, 32'hA000_003D};
        vecs[1] = '{5'd2,  32'h1234_0000, 1, 61, 32'h1234_0001, 32'h1234_003D};
        vecs[2] = '{5'd31, 32'hFFFF_FFF0, 2, 61, 32'hFFFF_FFF1, 32'h0000_002D};
        vecs[3] = '{5'd0,  32'h0000_0000, 1, 61, 32'h0000_0001, 32'h0000_003D};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_last", word_last, 0);
        chk("rst_word_data", word_data, 0);
        chk("rst_word_chan", word_chan, 0);
        chk("rst_ldac", ldac, 0);
        chk("rst_busy", busy, 0);
        chk("rst_launch_go", launch_go, 0);
        chk("rst_launch_cmd", launch_cmd_out, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Table-driven single frames.
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].ready_mode;
            hs_cnt = 0;
            drive(1, 1, vecs[v].chan, vecs[v].base, 0, '0);
            @(negedge clk);
            chk("first_valid", word_valid, 1);
            chk("first_data", word_data, vecs[v].exp_first);
            chk("first_chan", word_chan, vecs[v].chan);
            wait_idle($sformatf("vec%0d", v), 600);
            chk("hs_count", hs_cnt, vecs[v].exp_hs);
            chk("last_data", last_data, vecs[v].exp_last);
            chk("sb_drained", sb.size(), 0);
            chk("drop_none", drop_cnt, 0);
        end

        // Frames A, B, C five cycles apart: B is overwritten by C.
        ready_mode = 0;
        hs_cnt = 0;
        drive(1, 1, 5'd1, 32'hA100_0000, 0, '0);
        repeat (3) tick();
        drive(1, 0, 5'd2, 32'hB200_0000, 0, '0);
        repeat (3) tick();
        drive(1, 1, 5'd3, 32'hC300_0000, 0, '0);
        wait_idle("abc", 800);
        chk("abc_hs_count", hs_cnt, 122);
        chk("abc_sb_drained", sb.size(), 0);
        chk("abc_drop_cnt", drop_cnt, exp_drop);

        // Launch arriving mid-stream waits for the LDAC pulse to finish.
        go_cnt = 0;
        hs_cnt = 0;
        drive(1, 1, 5'd1, 32'hB000_0000, 0, '0);
        repeat (20) tick();
        drive(0, 0, 5'd0, 32'h0, 1, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF);
        wait_idle("launch_mid", 600);
        repeat (3) @(negedge clk);
        chk("launch_mid_go_cnt", go_cnt, 1);
        chk("launch_mid_hs", hs_cnt, 61);

        // Launch and frame in the same IDLE cycle: frame goes first.
        go_cnt = 0;
        hs_cnt = 0;
        drive(1, 1, 5'd4, 32'hC000_0000, 1, 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0);
        wait_idle("launch_same", 600);
        repeat (3) @(negedge clk);
        chk("launch_same_go_cnt", go_cnt, 1);
        chk("launch_same_hs", hs_cnt, 61);

        // Launch alone in IDLE releases promptly.
        go_cnt = 0;
        ldac_done = 1;
        drive(0, 0, 5'd0, 32'h0, 1, 128'h0F0F_0F0F_1111_2222_3333_4444_5555_6666);
        wait_idle("launch_idle", 10);
        repeat (2) @(negedge clk);
        chk("launch_idle_go_cnt", go_cnt, 1);

        // Reset while word 30 is presented, with a launch pending.
        go_cnt = 0;
        hs_cnt = 0;
        drive(1, 1, 5'd9, 32'hD000_0000, 0, '0);
        drive(0, 0, 5'd0, 32'h0, 1, 128'h7777_0000_7777_0000_7777_0000_7777_0000);
        n = 0;
        while (hs_cnt < 29 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_word30", hs_cnt, 29);
        @(posedge clk);
        #2;
        chk("pre_rst_data", word_data, 32'hD000_001E);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", word_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ldac", ldac, 0);
        sb.delete();
        r_ldac = ldac_rise_cnt;
        r_go   = go_cnt;
        r_hs   = hs_cnt;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_rst_valid", word_valid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_no_ldac", ldac_rise_cnt, r_ldac);
        chk("post_rst_no_go", go_cnt, r_go);
        chk("post_rst_no_words", hs_cnt, r_hs);
        chk("post_rst_drop", drop_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
